sap_datapath: RTL and testbench

Execution-side responder for the 8-bit CPU's 15-bit control word. It holds the PC, MAR, MDR, 16×8 RAM, IR, accumulator A, register B, the add/sub ALU, the output register, and the internal 8-bit bus. It samples the control word that the control block drives on the falling edge, acts on it at the next rising edge, and returns the current opcode to the control block.

---
 rtl/sap_pkg.sv | 47 ++++
 rtl/sap_datapath_if.sv | 27 ++
 rtl/sap_ram16x8.sv | 29 ++
 rtl/sap_datapath.sv | 132 +++++++++++++
 tb/tb_sap_datapath.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the 8-bit CPU: control word bit positions, the idle
// control word, opcode encodings and the ALU helper.
package sap_pkg;

  localparam int unsigned CTRL_W = 15;

  // Control word bit indices; a _N suffix marks an active-low signal.
  localparam int unsigned SIG_PC_INC     = 14;
  localparam int unsigned SIG_PC_EN      = 13;
  localparam int unsigned SIG_PC_LOAD    = 12;
  localparam int unsigned SIG_MAR_LOAD_N = 11;
  localparam int unsigned SIG_MDR_LOAD_N = 10;
  localparam int unsigned SIG_RAM_EN_N   = 9;
  localparam int unsigned SIG_RAM_WE_N   = 8;
  localparam int unsigned SIG_IR_LOAD_N  = 7;
  localparam int unsigned SIG_IR_EN_N    = 6;
  localparam int unsigned SIG_A_LOAD_N   = 5;
  localparam int unsigned SIG_A_EN       = 4;
  localparam int unsigned SIG_SUB        = 3;
  localparam int unsigned SIG_ALU_EN     = 2;
  localparam int unsigned SIG_B_LOAD_N   = 1;
  localparam int unsigned SIG_OUT_LOAD_N = 0;

  // Every signal deasserted: no bus drivers, no register loads.
  localparam logic [CTRL_W-1:0] IDLE_CTRL = 15'h0FE3;

  typedef enum logic [3:0] {
    OP_HLT = 4'h0,
    OP_NOP = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_LDA = 4'h4,
    OP_OUT = 4'h5,
    OP_STA = 4'h6,
    OP_JMP = 4'h7
  } opcode_e;

  // 9-bit add/subtract; bit 8 is carry, or "no borrow" when subtracting.
  function automatic logic [8:0] alu_add_sub(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic       sub);
    logic [8:0] w_b_ext;
    w_b_ext = sub ? {1'b0, ~b} : {1'b0, b};
    return {1'b0, a} + w_b_ext + {8'h00, sub};
  endfunction

endpackage

// File: rtl/sap_datapath_if.sv
// Control-block / program-loader side of the datapath: control word and
// program write port in, opcode, output register, flags and bus debug out.
interface sap_datapath_if;
  import sap_pkg::*;

  logic [CTRL_W-1:0] ctrl;
  logic              prog_we;
  logic [3:0]        prog_addr;
  logic [7:0]        prog_data;
  logic [3:0]        opcode;
  logic [7:0]        out_port;
  logic              flag_z;
  logic              flag_c;
  logic [7:0]        bus_dbg;
  logic              bus_conflict;

  // Control word is a level sampled at every posedge; there is no handshake.
  modport master (
    output ctrl, prog_we, prog_addr, prog_data,
    input  opcode, out_port, flag_z, flag_c, bus_dbg, bus_conflict
  );

  modport slave (
    input  ctrl, prog_we, prog_addr, prog_data,
    output opcode, out_port, flag_z, flag_c, bus_dbg, bus_conflict
  );
endinterface

// File: rtl/sap_ram16x8.sv
// Program/data RAM: asynchronous read, two write ports where the external
// program port always beats the CPU port. Contents are never reset.
module sap_ram16x8 #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       i_cpu_we,
  input  logic [3:0] i_cpu_addr,
  input  logic [7:0] i_cpu_data,
  input  logic       i_prog_we,
  input  logic [3:0] i_prog_addr,
  input  logic [7:0] i_prog_data,
  input  logic [3:0] i_rd_addr,
  output logic [7:0] o_rd_data
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_prog_we) begin
      r_mem[i_prog_addr] <= i_prog_data;
    end else if (i_cpu_we) begin
      r_mem[i_cpu_addr] <= i_cpu_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sap_datapath.sv
// Execution datapath of the 8-bit CPU: PC, MAR, MDR, RAM, IR, A, B, ALU and
// output register around a single prioritised 8-bit bus.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int unsigned       RAM_DEPTH = 16,
  parameter logic [CTRL_W-1:0] IDLE_CTRL = sap_pkg::IDLE_CTRL
) (
  input  logic           clk,
  input  logic           rst_n,
  sap_datapath_if.slave  bus_if
);

  logic [3:0] r_pc;
  logic [3:0] r_mar;
  logic [7:0] r_mdr;
  logic [7:0] r_ir;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_out;
  logic       r_flag_z;
  logic       r_flag_c;
  logic       r_conflict;

  // Substituting the idle word in reset suppresses every load and driver,
  // which also keeps the all-zero reset control word from flagging a conflict.
  logic [CTRL_W-1:0] w_ctrl;
  assign w_ctrl = rst_n ? bus_if.ctrl : IDLE_CTRL;

  logic w_pc_inc, w_pc_en, w_pc_load, w_mar_load, w_mdr_load, w_ram_en;
  logic w_ram_we, w_ir_load, w_ir_en, w_a_load, w_a_en, w_sub, w_alu_en;
  logic w_b_load, w_out_load;

  assign w_pc_inc   =  w_ctrl[SIG_PC_INC];
  assign w_pc_en    =  w_ctrl[SIG_PC_EN];
  assign w_pc_load  =  w_ctrl[SIG_PC_LOAD];
  assign w_mar_load = ~w_ctrl[SIG_MAR_LOAD_N];
  assign w_mdr_load = ~w_ctrl[SIG_MDR_LOAD_N];
  assign w_ram_en   = ~w_ctrl[SIG_RAM_EN_N];
  assign w_ram_we   = ~w_ctrl[SIG_RAM_WE_N];
  assign w_ir_load  = ~w_ctrl[SIG_IR_LOAD_N];
  assign w_ir_en    = ~w_ctrl[SIG_IR_EN_N];
  assign w_a_load   = ~w_ctrl[SIG_A_LOAD_N];
  assign w_a_en     =  w_ctrl[SIG_A_EN];
  assign w_sub      =  w_ctrl[SIG_SUB];
  assign w_alu_en   =  w_ctrl[SIG_ALU_EN];
  assign w_b_load   = ~w_ctrl[SIG_B_LOAD_N];
  assign w_out_load = ~w_ctrl[SIG_OUT_LOAD_N];

  logic [7:0] w_ram_rd;

  sap_ram16x8 #(
    .DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk         (clk),
    .i_cpu_we    (w_ram_we),
    .i_cpu_addr  (r_mar),
    .i_cpu_data  (r_mdr),
    .i_prog_we   (bus_if.prog_we),
    .i_prog_addr (bus_if.prog_addr),
    .i_prog_data (bus_if.prog_data),
    .i_rd_addr   (r_mar),
    .o_rd_data   (w_ram_rd)
  );

  logic [8:0] w_alu;
  assign w_alu = alu_add_sub(r_a, r_b, w_sub);

  logic [7:0] w_bus;
  always_comb begin
    w_bus = 8'h00;
    if (w_ram_en) begin
      w_bus = w_ram_rd;
    end else if (w_ir_en) begin
      w_bus = {4'h0, r_ir[3:0]};
    end else if (w_alu_en) begin
      w_bus = w_alu[7:0];
    end else if (w_a_en) begin
      w_bus = r_a;
    end else if (w_pc_en) begin
      w_bus = {4'h0, r_pc};
    end
  end

  logic [4:0] w_drivers;
  logic       w_multi_drive;
  assign w_drivers     = {w_ram_en, w_ir_en, w_alu_en, w_a_en, w_pc_en};
  assign w_multi_drive = ($countones(w_drivers) > 1);

  logic w_flag_update;
  assign w_flag_update = w_a_load && w_alu_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= 4'h0;
      r_mar      <= 4'h0;
      r_mdr      <= 8'h00;
      r_ir       <= 8'h00;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_out      <= 8'h00;
      r_flag_z   <= 1'b0;
      r_flag_c   <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      if (w_pc_load) begin
        r_pc <= w_bus[3:0];
      end else if (w_pc_inc) begin
        r_pc <= r_pc + 4'd1;
      end
      if (w_mar_load) r_mar <= w_bus[3:0];
      if (w_mdr_load) r_mdr <= w_bus;
      if (w_ir_load)  r_ir  <= w_bus;
      if (w_a_load)   r_a   <= w_bus;
      if (w_b_load)   r_b   <= w_bus;
      if (w_out_load) r_out <= w_bus;
      if (w_flag_update) begin
        r_flag_z <= (w_alu[7:0] == 8'h00);
        r_flag_c <= w_alu[8];
      end
      if (w_multi_drive) r_conflict <= 1'b1;
    end
  end

  assign bus_if.opcode       = r_ir[7:4];
  assign bus_if.out_port     = r_out;
  assign bus_if.flag_z       = r_flag_z;
  assign bus_if.flag_c       = r_flag_c;
  assign bus_if.bus_dbg      = w_bus;
  assign bus_if.bus_conflict = r_conflict;

endmodule

// File: tb/tb_sap_datapath.sv
// Bench for sap_datapath: table of ALU vectors plus hand-written sequences
// for fetch, store, program-port priority, PC wrap/jump, bus conflict, reset.
module tb_sap_datapath;
  import sap_pkg::*;

  logic clk;
  logic rst_n;

  sap_datapath_if dp_if ();

  sap_datapath #(
    .RAM_DEPTH (16),
    .IDLE_CTRL (IDLE_CTRL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (dp_if)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [7:0] exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [3:0] mar_m = 4'h0;

  task automatic check(input string name, input logic [7:0] act);
    logic [7:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got %h but no expected value queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  task automatic expect_now(input string name, input logic [7:0] exp, input logic [7:0] act);
    exp_q.push_back(exp);
    check(name, act);
  endtask

  function automatic logic [14:0] sg(input int unsigned b);
    logic [14:0] one;
    one = 15'd1;
    return one << b;
  endfunction

  // Driver tasks: ctrl is set at negedge, asserting the bits in m
  task automatic drive(input logic [14:0] m, input logic pwe,
                       input logic [3:0] pa, input logic [7:0] pd);
    @(negedge clk);
    dp_if.ctrl      = IDLE_CTRL ^ m;
    dp_if.prog_we   = pwe;
    dp_if.prog_addr = pa;
    dp_if.prog_data = pd;
    @(posedge clk);
    #1;
    dp_if.prog_we = 1'b0;
  endtask

  task automatic apply(input logic [14:0] m);
    drive(m, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d);
    drive(15'h0, 1'b1, a, d);
  endtask

  // Stage v in RAM[MAR] and load it into the register(s) selected by m
  task automatic ld(input logic [14:0] m, input logic [7:0] v);
    prog(mar_m, v);
    apply(sg(SIG_RAM_EN_N) | m);
    if ((m & sg(SIG_MAR_LOAD_N)) != 15'h0) mar_m = v[3:0];
  endtask

  task automatic peek(input string name, input logic [14:0] m, input logic [7:0] exp);
    @(negedge clk);
    dp_if.ctrl = IDLE_CTRL ^ m;
    exp_q.push_back(exp);
    #2;
    check(name, dp_if.bus_dbg);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
  } alu_vec_t;

  alu_vec_t   vecs[6];
  logic [8:0] model;
  logic [7:0] exp_a;
  logic       exp_z;
  logic       exp_c;
  logic [7:0] last_a;
  logic [7:0] last_b;

  initial begin
    vecs[0] = '{8'h05, 8'h07, 1'b0};
    vecs[1] = '{8'h0C, 8'h0C, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0};
    vecs[3] = '{8'h03, 8'h05, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0};
    vecs[5] = '{8'h10, 8'h01, 1'b1};

    // Reset with the all-zero control word, loading a program meanwhile
    rst_n           = 1'b0;
    dp_if.ctrl      = 15'h0;
    dp_if.prog_we   = 1'b0;
    dp_if.prog_addr = 4'h0;
    dp_if.prog_data = 8'h00;
    @(negedge clk);
    dp_if.prog_we   = 1'b1;
    dp_if.prog_addr = 4'h0;
    dp_if.prog_data = 8'h2E;
    @(posedge clk);
    #1;
    dp_if.prog_we = 1'b0;
    @(posedge clk);
    #1;
    expect_now("conflict_in_reset", 8'h00, {7'h0, dp_if.bus_conflict});

    @(negedge clk);
    rst_n      = 1'b1;
    dp_if.ctrl = IDLE_CTRL;
    #2;
    expect_now("rst_opcode",   8'h00, {4'h0, dp_if.opcode});
    expect_now("rst_out",      8'h00, dp_if.out_port);
    expect_now("rst_flag_z",   8'h00, {7'h0, dp_if.flag_z});
    expect_now("rst_flag_c",   8'h00, {7'h0, dp_if.flag_c});
    expect_now("rst_bus",      8'h00, dp_if.bus_dbg);
    expect_now("rst_conflict", 8'h00, {7'h0, dp_if.bus_conflict});

    // Fetch: MAR <- PC, then IR <- RAM[MAR] with PC increment
    apply(sg(SIG_PC_EN) | sg(SIG_MAR_LOAD_N));
    apply(sg(SIG_RAM_EN_N) | sg(SIG_IR_LOAD_N) | sg(SIG_PC_INC));
    expect_now("fetch_opcode", 8'h02, {4'h0, dp_if.opcode});
    peek("fetch_ir_low", sg(SIG_IR_EN_N), 8'h0E);
    peek("fetch_pc", sg(SIG_PC_EN), 8'h01);

    // ALU table: expected result pushed when the operation is driven
    foreach (vecs[i]) begin
      ld(sg(SIG_A_LOAD_N), vecs[i].a);
      ld(sg(SIG_B_LOAD_N), vecs[i].b);
      model = vecs[i].sub ? ({1'b0, vecs[i].a} + {1'b0, 8'hFF - vecs[i].b} + 9'd1)
                          : ({1'b0, vecs[i].a} + {1'b0, vecs[i].b});
      exp_a = model[7:0];
      exp_z = (model[7:0] == 8'h00);
      exp_c = model[8];
      exp_q.push_back(exp_a);
      apply(sg(SIG_ALU_EN) | sg(SIG_A_LOAD_N) | (vecs[i].sub ? sg(SIG_SUB) : 15'h0));
      check("alu_flag_z_pre", {7'h0, dp_if.flag_z} ^ {7'h0, exp_z} ^ exp_a);
      expect_now("alu_flag_z", {7'h0, exp_z}, {7'h0, dp_if.flag_z});
      expect_now("alu_flag_c", {7'h0, exp_c}, {7'h0, dp_if.flag_c});
      peek("alu_result_a", sg(SIG_A_EN), exp_a);
    end
    last_a = exp_a;
    last_b = vecs[5].b;

    // ALU onto the bus without an A load: flags hold
    apply(sg(SIG_ALU_EN) | sg(SIG_OUT_LOAD_N));
    expect_now("alu_to_out", last_a + last_b, dp_if.out_port);
    expect_now("flag_z_hold", {7'h0, exp_z}, {7'h0, dp_if.flag_z});
    expect_now("flag_c_hold", {7'h0, exp_c}, {7'h0, dp_if.flag_c});
    // Read and reload A in the same cycle keeps its value
    apply(sg(SIG_A_EN) | sg(SIG_A_LOAD_N));
    peek("a_self_reload", sg(SIG_A_EN), last_a);

    // STA: MAR = 9, MDR = A5, write, read back through the output register
    ld(sg(SIG_A_LOAD_N), 8'hA5);
    ld(sg(SIG_MAR_LOAD_N), 8'h09);
    prog(4'h9, 8'h00);
    apply(sg(SIG_A_EN) | sg(SIG_MDR_LOAD_N));
    apply(sg(SIG_RAM_WE_N));
    apply(sg(SIG_RAM_EN_N) | sg(SIG_OUT_LOAD_N));
    expect_now("sta_readback", 8'hA5, dp_if.out_port);
    drive(sg(SIG_RAM_WE_N), 1'b1, 4'h9, 8'h3C);
    apply(sg(SIG_RAM_EN_N) | sg(SIG_OUT_LOAD_N));
    expect_now("prog_wins_same_addr", 8'h3C, dp_if.out_port);
    drive(sg(SIG_RAM_WE_N), 1'b1, 4'h3, 8'h77);
    apply(sg(SIG_RAM_EN_N) | sg(SIG_OUT_LOAD_N));
    expect_now("cpu_write_dropped", 8'h3C, dp_if.out_port);

    // PC load, wrap and load-over-increment
    ld(sg(SIG_A_LOAD_N), 8'h0F);
    apply(sg(SIG_A_EN) | sg(SIG_PC_LOAD));
    peek("pc_load_15", sg(SIG_PC_EN), 8'h0F);
    apply(sg(SIG_PC_INC));
    peek("pc_wrap", sg(SIG_PC_EN), 8'h00);
    ld(sg(SIG_A_LOAD_N), 8'h07);
    apply(sg(SIG_A_EN) | sg(SIG_PC_LOAD) | sg(SIG_PC_INC));
    peek("pc_jmp", sg(SIG_PC_EN), 8'h07);

    // Conflict detection and driver priority (A = 07, B = 01, IR = 2E)
    expect_now("no_conflict_yet", 8'h00, {7'h0, dp_if.bus_conflict});
    peek("conflict_bus_a", sg(SIG_A_EN) | sg(SIG_PC_EN), 8'h07);
    expect_now("conflict_set", 8'h01, {7'h0, dp_if.bus_conflict});
    apply(15'h0);
    expect_now("conflict_sticky", 8'h01, {7'h0, dp_if.bus_conflict});
    prog(4'h9, 8'h5A);
    peek("prio_ram", sg(SIG_RAM_EN_N) | sg(SIG_IR_EN_N) | sg(SIG_ALU_EN) |
         sg(SIG_A_EN) | sg(SIG_PC_EN), 8'h5A);
    peek("prio_ir", sg(SIG_IR_EN_N) | sg(SIG_ALU_EN) | sg(SIG_A_EN) | sg(SIG_PC_EN), 8'h0E);
    peek("prio_alu", sg(SIG_ALU_EN) | sg(SIG_A_EN) | sg(SIG_PC_EN), 8'h08);

    // Second reset: state cleared, RAM retained
    @(negedge clk);
    rst_n      = 1'b0;
    dp_if.ctrl = 15'h0;
    repeat (2) @(posedge clk);
    #1;
    expect_now("rst2_conflict", 8'h00, {7'h0, dp_if.bus_conflict});
    expect_now("rst2_out", 8'h00, dp_if.out_port);
    expect_now("rst2_opcode", 8'h00, {4'h0, dp_if.opcode});
    expect_now("rst2_flag_c", 8'h00, {7'h0, dp_if.flag_c});
    @(negedge clk);
    rst_n      = 1'b1;
    dp_if.ctrl = IDLE_CTRL;
    mar_m      = 4'h0;
    peek("rst2_a", sg(SIG_A_EN), 8'h00);
    apply(sg(SIG_RAM_EN_N) | sg(SIG_OUT_LOAD_N));
    expect_now("ram_retained", 8'h09, dp_if.out_port);

    // Final report
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected values left unchecked", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
